// File: rtl/conv_window_gen.sv
// Raster-order pixel stream to 3x3 sliding-window generator.
// Two line buffers feed a shift window; only fully-populated windows are emitted.
module conv_window_gen #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned IMG_W  = 8,
   parameter int unsigned IMG_H  = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                ena,
   input  logic [DATA_W-1:0]   pix_in,
   input  logic                pix_valid,
   output logic                pix_ready,
   output logic [9*DATA_W-1:0] win_out,
   output logic                win_valid,
   input  logic                win_ready,
   output logic                frame_done
);

   localparam int unsigned ColW = $clog2(IMG_W);
   localparam int unsigned RowW = $clog2(IMG_H);
   localparam logic [ColW-1:0] ColLast = ColW'(IMG_W - 1);
   localparam logic [RowW-1:0] RowLast = RowW'(IMG_H - 1);

   logic [ColW-1:0]     col_q, col_d;
   logic [RowW-1:0]     row_q, row_d;
   logic [DATA_W-1:0]   lb0_q [IMG_W];
   logic [DATA_W-1:0]   lb1_q [IMG_W];
   logic [DATA_W-1:0]   win_q [9];
   logic [DATA_W-1:0]   win_d [9];
   logic [9*DATA_W-1:0] win_out_q, win_out_d;
   logic                win_valid_q, win_valid_d;
   logic                frame_done_q, frame_done_d;
   logic                accept, emit, col_wrap, frame_end;

   assign pix_ready  = ena & (~win_valid_q | win_ready);
   assign win_out    = win_out_q;
   assign win_valid  = win_valid_q;
   assign frame_done = frame_done_q;

   always_comb begin
      accept    = pix_valid & pix_ready;
      col_wrap  = (col_q == ColLast);
      frame_end = col_wrap & (row_q == RowLast);
      // Windows touching column 0/1 or row 0/1 hold stale data and are masked.
      emit      = accept & (row_q >= RowW'(2)) & (col_q >= ColW'(2));
   end

   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (accept) begin
         if (col_wrap) begin
            col_d = '0;
            row_d = (row_q == RowLast) ? '0 : row_q + 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end
      end
   end

   always_comb begin
      for (int k = 0; k < 9; k++) begin
         win_d[k] = win_q[k];
      end
      if (accept) begin
         for (int r = 0; r < 3; r++) begin
            win_d[3*r]   = win_q[3*r+1];
            win_d[3*r+1] = win_q[3*r+2];
         end
         win_d[2] = lb1_q[col_q];
         win_d[5] = lb0_q[col_q];
         win_d[8] = pix_in;
      end
   end

   always_comb begin
      win_out_d    = win_out_q;
      win_valid_d  = win_valid_q;
      frame_done_d = accept & frame_end;
      if (emit) begin
         for (int k = 0; k < 9; k++) begin
            win_out_d[DATA_W*k +: DATA_W] = win_d[k];
         end
      end
      if (ena) begin
         if (emit) begin
            win_valid_d = 1'b1;
         end else if (win_valid_q & win_ready) begin
            win_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         col_q        <= '0;
         row_q        <= '0;
         win_out_q    <= '0;
         win_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
         for (int i = 0; i < int'(IMG_W); i++) begin
            lb0_q[i] <= '0;
            lb1_q[i] <= '0;
         end
         for (int k = 0; k < 9; k++) begin
            win_q[k] <= '0;
         end
      end else begin
         col_q        <= col_d;
         row_q        <= row_d;
         win_out_q    <= win_out_d;
         win_valid_q  <= win_valid_d;
         frame_done_q <= frame_done_d;
         for (int k = 0; k < 9; k++) begin
            win_q[k] <= win_d[k];
         end
         if (accept) begin
            lb1_q[col_q] <= lb0_q[col_q];
            lb0_q[col_q] <= pix_in;
         end
      end
   end

endmodule

// File: tb/tb_conv_window_gen.sv
// Scoreboard bench for conv_window_gen: driver pushes expected windows, a monitor pops on each take.
module tb_conv_window_gen;

   localparam int DATA_W = 8;
   localparam int IMG_W  = 8;
   localparam int IMG_H  = 8;
   localparam int NPIX   = IMG_W * IMG_H;

   localparam logic [9*DATA_W-1:0] WinFirst0 =
      {8'd18, 8'd17, 8'd16, 8'd10, 8'd9, 8'd8, 8'd2, 8'd1, 8'd0};
   localparam logic [9*DATA_W-1:0] WinLast0 =
      {8'd63, 8'd62, 8'd61, 8'd55, 8'd54, 8'd53, 8'd47, 8'd46, 8'd45};
   localparam logic [9*DATA_W-1:0] WinFirst100 =
      {8'd118, 8'd117, 8'd116, 8'd110, 8'd109, 8'd108, 8'd102, 8'd101, 8'd100};

   logic                clk = 1'b0;
   logic                rst_n;
   logic                ena;
   logic [DATA_W-1:0]   pix_in;
   logic                pix_valid;
   logic                pix_ready;
   logic [9*DATA_W-1:0] win_out;
   logic                win_valid;
   logic                win_ready = 1'b0;
   logic                frame_done;

   logic                rdy_mode = 1'b0;
   logic                rdy_val  = 1'b1;
   logic [9*DATA_W-1:0] exp_q [$];
   int                  checks = 0;
   int                  errors = 0;
   int                  acc_cnt = 0;
   int                  fd_cnt = 0;
   int                  fd_base;

   conv_window_gen #(
      .DATA_W (DATA_W),
      .IMG_W  (IMG_W),
      .IMG_H  (IMG_H)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ena        (ena),
      .pix_in     (pix_in),
      .pix_valid  (pix_valid),
      .pix_ready  (pix_ready),
      .win_out    (win_out),
      .win_valid  (win_valid),
      .win_ready  (win_ready),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1;
      win_ready = rdy_mode ? 1'($urandom_range(0, 1)) : rdy_val;
   end

   // Monitor: a window is taken when valid, ready and enabled meet at the coming edge.
   always @(negedge clk) begin
      if (rst_n && ena && win_valid && win_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL window_unexpected: got %h, want none", win_out);
         end else begin
            logic [9*DATA_W-1:0] exp_w;
            exp_w = exp_q.pop_front();
            if (win_out !== exp_w) begin
               errors++;
               $display("FAIL window: got %h, want %h", win_out, exp_w);
            end
         end
      end
      if (frame_done) fd_cnt++;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [9*DATA_W-1:0] act,
                      input logic [9*DATA_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   function automatic logic [9*DATA_W-1:0] exp_win(input int base, input int r, input int c);
      logic [9*DATA_W-1:0] w;
      w = '0;
      for (int k = 0; k < 9; k++) begin
         w[DATA_W*k +: DATA_W] = DATA_W'(base + IMG_W * (r - 2 + k / 3) + (c - 2 + k % 3));
      end
      return w;
   endfunction

   task automatic push_frame(input int base);
      for (int r = 2; r < IMG_H; r++) begin
         for (int c = 2; c < IMG_W; c++) begin
            exp_q.push_back(exp_win(base, r, c));
         end
      end
   endtask

   task automatic send_pixels(input int base, input int n, input bit gaps);
      for (int i = 0; i < n; i++) begin
         bit done;
         int guard;
         done  = 1'b0;
         guard = 0;
         while (!done) begin
            pix_valid = !(gaps && $urandom_range(0, 2) == 0);
            pix_in    = DATA_W'(base + i);
            @(negedge clk);
            if (pix_valid && pix_ready) begin
               done = 1'b1;
               acc_cnt++;
            end
            @(posedge clk);
            #1;
            guard++;
            if (guard > 2000) begin
               $display("FAIL pixel_stall: got no accept, want accept of pixel %0d", i);
               $fatal(1, "stall");
            end
         end
      end
      pix_valid = 1'b0;
   endtask

   task automatic wait_valid(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(posedge clk);
         #2;
         if (win_valid) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_acc(input int n, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk);
         #2;
         if (acc_cnt >= n) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !win_valid) break;
      end
      chk("drain_pending", 72'(exp_q.size()), 72'd0);
      chk("drain_valid", 72'(win_valid), 72'd0);
   endtask

   task automatic start();
      acc_cnt = 0;
      fd_base = fd_cnt;
      @(posedge clk);
      #1;
   endtask

   initial begin
      bit ok;
      logic [9*DATA_W-1:0] hold_w;
      logic                hold_v;
      int                  hold_acc;

      rst_n     = 1'b0;
      ena       = 1'b1;
      pix_valid = 1'b0;
      pix_in    = '0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("reset_win_valid", 72'(win_valid), 72'd0);
      chk("reset_win_out", win_out, 72'd0);
      chk("reset_frame_done", 72'(frame_done), 72'd0);
      chk("reset_pix_ready", 72'(pix_ready), 72'd1);

      // 1: plain frame, always ready
      start();
      push_frame(0);
      fork
         send_pixels(0, NPIX, 1'b0);
         begin
            wait_valid(ok);
            chk("s1_first_wait", 72'(ok), 72'd1);
            chk("s1_first_latency", 72'(acc_cnt), 72'd19);
            chk("s1_first_window", win_out, WinFirst0);
            wait_acc(NPIX, ok);
            chk("s1_last_wait", 72'(ok), 72'd1);
            chk("s1_frame_done_high", 72'(frame_done), 72'd1);
            chk("s1_last_window", win_out, WinLast0);
            @(posedge clk);
            #2;
            chk("s1_frame_done_low", 72'(frame_done), 72'd0);
         end
      join
      drain();
      chk("s1_frame_done_count", 72'(fd_cnt - fd_base), 72'd1);

      // 2: backpressure on the first window
      rdy_val = 1'b0;
      start();
      push_frame(0);
      fork
         send_pixels(0, NPIX, 1'b0);
         begin
            wait_valid(ok);
            chk("s2_first_wait", 72'(ok), 72'd1);
            for (int i = 0; i < 5; i++) begin
               @(negedge clk);
               chk("s2_hold_valid", 72'(win_valid), 72'd1);
               chk("s2_hold_window", win_out, WinFirst0);
               chk("s2_hold_pix_ready", 72'(pix_ready), 72'd0);
            end
            chk("s2_hold_accepts", 72'(acc_cnt), 72'd19);
            rdy_val = 1'b1;
         end
      join
      drain();
      chk("s2_frame_done_count", 72'(fd_cnt - fd_base), 72'd1);

      // 3: random input gaps and random downstream ready
      rdy_mode = 1'b1;
      start();
      push_frame(0);
      send_pixels(0, NPIX, 1'b1);
      drain();
      rdy_mode = 1'b0;
      chk("s3_frame_done_count", 72'(fd_cnt - fd_base), 72'd1);

      // 4: two back-to-back frames
      start();
      push_frame(0);
      push_frame(100);
      fork
         begin
            send_pixels(0, NPIX, 1'b0);
            send_pixels(100, NPIX, 1'b0);
         end
         begin
            wait_acc(NPIX + 19, ok);
            chk("s4_second_wait", 72'(ok), 72'd1);
            chk("s4_second_valid", 72'(win_valid), 72'd1);
            chk("s4_second_first_window", win_out, WinFirst100);
         end
      join
      drain();
      chk("s4_frame_done_count", 72'(fd_cnt - fd_base), 72'd2);

      // 5: reset mid-frame, then a fresh frame
      start();
      exp_q.push_back(exp_win(0, 2, 2));
      exp_q.push_back(exp_win(0, 2, 3));
      exp_q.push_back(exp_win(0, 2, 4));
      send_pixels(0, 21, 1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("s5_reset_valid", 72'(win_valid), 72'd0);
      chk("s5_reset_win_out", win_out, 72'd0);
      chk("s5_reset_frame_done", 72'(frame_done), 72'd0);
      chk("s5_partial_taken", 72'(exp_q.size()), 72'd0);
      start();
      push_frame(0);
      send_pixels(0, NPIX, 1'b0);
      drain();
      chk("s5_frame_done_count", 72'(fd_cnt - fd_base), 72'd1);

      // 6: enable low for four cycles mid-frame
      start();
      push_frame(0);
      fork
         send_pixels(0, NPIX, 1'b0);
         begin
            wait_acc(30, ok);
            chk("s6_wait", 72'(ok), 72'd1);
            ena = 1'b0;
            @(negedge clk);
            hold_w   = win_out;
            hold_v   = win_valid;
            hold_acc = acc_cnt;
            chk("s6_pix_ready", 72'(pix_ready), 72'd0);
            for (int i = 0; i < 3; i++) begin
               @(negedge clk);
               chk("s6_pix_ready", 72'(pix_ready), 72'd0);
               chk("s6_win_out_frozen", win_out, hold_w);
               chk("s6_win_valid_frozen", 72'(win_valid), 72'(hold_v));
               chk("s6_frame_done", 72'(frame_done), 72'd0);
            end
            chk("s6_no_accepts", 72'(acc_cnt), 72'(hold_acc));
            @(posedge clk);
            #2;
            ena = 1'b1;
         end
      join
      drain();
      chk("s6_frame_done_count", 72'(fd_cnt - fd_base), 72'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
